// File: rtl/led_seq_ctrl.sv
// ============================================================================
// led_seq_ctrl : command-driven 16-bit LED pattern sequencer (ROTL/ROTR/BOUNCE/BLINK)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_seq_ctrl #(
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_period,
  output logic [15:0]      ledr,
  output logic             step,
  output logic [1:0]       cur_mode,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    APPLY = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_t           state_q;
  logic [15:0]      ledr_q;
  logic [15:0]      ledr_d;
  logic             dir_q;
  logic             dir_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       hold_mode_q;
  logic [CNT_W-1:0] hold_period_q;
  logic             step_q;
  logic             accept;

  assign cmd_ready = (state_q != APPLY);
  assign accept    = cmd_valid && cmd_ready;
  assign ledr      = ledr_q;
  assign step      = step_q;
  assign cur_mode  = mode_q;
  assign running   = (state_q == RUN);

  // Pattern that the next tick would produce in the current mode
  always_comb begin
    ledr_d = ledr_q;
    dir_d  = dir_q;
    case (mode_q)
      2'd0: ledr_d = {ledr_q[14:0], ledr_q[15]};
      2'd1: ledr_d = {ledr_q[0], ledr_q[15:1]};
      2'd2: begin
        if (dir_q == DIR_LEFT) begin
          if (ledr_q[15]) begin
            dir_d  = DIR_RIGHT;
            ledr_d = ledr_q >> 1;
          end else begin
            ledr_d = ledr_q << 1;
          end
        end else begin
          if (ledr_q[0]) begin
            dir_d  = DIR_LEFT;
            ledr_d = ledr_q << 1;
          end else begin
            ledr_d = ledr_q >> 1;
          end
        end
      end
      default: ledr_d = ~ledr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      ledr_q        <= 16'h0001;
      dir_q         <= DIR_LEFT;
      mode_q        <= 2'd0;
      period_q      <= CNT_W'(DEF_PERIOD);
      count_q       <= '0;
      hold_mode_q   <= 2'd0;
      hold_period_q <= '0;
      step_q        <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (accept) begin
        hold_mode_q   <= cmd_mode;
        hold_period_q <= cmd_period;
      end
      case (state_q)
        IDLE: begin
          if (accept)     state_q <= APPLY;
          else if (start) state_q <= RUN;
        end
        RUN: begin
          if (accept) begin
            state_q <= APPLY;
          end else if (stop) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (pause) begin
            state_q <= PAUSE;
          end else if (count_q >= period_q) begin
            count_q <= '0;
            ledr_q  <= ledr_d;
            dir_q   <= dir_d;
            step_q  <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        PAUSE: begin
          if (accept) begin
            state_q <= APPLY;
          end else if (stop) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (!pause) begin
            state_q <= RUN;
          end
        end
        default: begin
          mode_q   <= hold_mode_q;
          period_q <= hold_period_q;
          count_q  <= '0;
          dir_q    <= DIR_LEFT;
          ledr_q   <= (hold_mode_q == 2'd3) ? 16'hFFFF : 16'h0001;
          state_q  <= RUN;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// ============================================================================
// tb_led_seq_ctrl : scoreboard bench; expected patterns queued per step pulse
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = 2'd0;
  logic [31:0] cmd_period = 32'd0;
  logic [15:0] ledr;
  logic        step;
  logic [1:0]  cur_mode;
  logic        running;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  led_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_period(cmd_period), .ledr(ledr), .step(step), .cur_mode(cur_mode),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each step pulse must match the next queued pattern
  always @(negedge clk) begin
    if (rst && step) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL step_unexpected: got ledr %h expected no step at %0t", ledr, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (ledr !== e) begin
          failures++;
          $display("FAIL step_ledr: got %h expected %h at %0t", ledr, e, $time);
        end
      end
    end
  end

  initial begin
    // Reset
    tick(2);
    rst = 1'b1;
    chk("rst_ledr", 32'(ledr), 32'h0001);
    chk("rst_mode", 32'(cur_mode), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_step", 32'(step), 32'd0);

    // ROTL, period 3
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004);
    cmd_mode = 2'd0; cmd_period = 32'd3; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    chk("apply_ready", 32'(cmd_ready), 32'd0);
    tick(1);
    chk("rotl_seed", 32'(ledr), 32'h0001);
    chk("rotl_running", 32'(running), 32'd1);
    tick(3);
    chk("rotl_hold", 32'(ledr), 32'h0001);
    tick(1);
    chk("rotl_first", 32'(ledr), 32'h0002);
    chk("rotl_step", 32'(step), 32'd1);
    tick(4);
    chk("rotl_second", 32'(ledr), 32'h0004);

    // Stop then restart
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_ledr", 32'(ledr), 32'h0004);
    tick(3);
    chk("idle_hold", 32'(ledr), 32'h0004);
    exp_q.push_back(16'h0008);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("restart_hold", 32'(ledr), 32'h0004);
    tick(1);
    chk("restart_step", 32'(ledr), 32'h0008);

    // BOUNCE, period 0
    for (int i = 1; i <= 15; i++) exp_q.push_back(16'(1 << i));
    for (int i = 14; i >= 0; i--) exp_q.push_back(16'(1 << i));
    exp_q.push_back(16'h0002);
    cmd_mode = 2'd2; cmd_period = 32'd0; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("bounce_seed", 32'(ledr), 32'h0001);
    chk("bounce_mode", 32'(cur_mode), 32'd2);
    tick(31);
    chk("bounce_end", 32'(ledr), 32'h0002);

    // BLINK, period 1, with a 5-cycle pause mid-period
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    cmd_mode = 2'd3; cmd_period = 32'd1; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("blink_seed", 32'(ledr), 32'hFFFF);
    tick(1);
    pause = 1'b1;
    tick(5);
    chk("pause_ledr", 32'(ledr), 32'hFFFF);
    chk("pause_running", 32'(running), 32'd0);
    pause = 1'b0;
    tick(1);
    chk("resume_running", 32'(running), 32'd1);
    tick(1);
    chk("blink_resume", 32'(ledr), 32'h0000);
    tick(2);
    chk("blink_2", 32'(ledr), 32'hFFFF);
    tick(2);
    chk("blink_3", 32'(ledr), 32'h0000);

    // Command + stop at count==period: command wins, no step
    tick(1);
    cmd_mode = 2'd0; cmd_period = 32'd2; cmd_valid = 1'b1; stop = 1'b1;
    tick(1);
    cmd_valid = 1'b0; stop = 1'b0;
    chk("prio_ledr", 32'(ledr), 32'h0000);
    chk("prio_ready", 32'(cmd_ready), 32'd0);
    tick(1);
    chk("prio_seed", 32'(ledr), 32'h0001);
    chk("prio_mode", 32'(cur_mode), 32'd0);
    exp_q.push_back(16'h0002);
    tick(3);
    chk("p2_step", 32'(ledr), 32'h0002);

    // Reset during PAUSE
    pause = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1; pause = 1'b0;
    chk("prst_ledr", 32'(ledr), 32'h0001);
    chk("prst_mode", 32'(cur_mode), 32'd0);
    chk("prst_running", 32'(running), 32'd0);
    chk("prst_ready", 32'(cmd_ready), 32'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    chk("defperiod_hold", 32'(ledr), 32'h0001);

    // ROTR, period 0; stop beats a due tick
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h4000);
    cmd_mode = 2'd1; cmd_period = 32'd0; cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("rotr_seed", 32'(ledr), 32'h0001);
    tick(2);
    chk("rotr_2", 32'(ledr), 32'h4000);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("rotr_stop", 32'(ledr), 32'h4000);
    chk("rotr_stop_run", 32'(running), 32'd0);

    tick(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the period register and tick counter.
REQ-002 Parameter: DEF_PERIOD, default 5000000, period value loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: 0 on a rising clk edge resets the block.
REQ-005 start  input  1  level; in IDLE, begins stepping.
REQ-006 stop  input  1  level; in RUN/PAUSE, returns to IDLE.
REQ-007 pause  input  1  level; freezes the counter and pattern while high in RUN/PAUSE.
REQ-008 cmd_valid  input  1  command offered.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready on a rising edge.
REQ-010 cmd_mode  input  2  0=ROTL, 1=ROTR, 2=BOUNCE, 3=BLINK.
REQ-011 cmd_period  input  CNT_W  tick period; one step every cmd_period+1 cycles.
REQ-012 ledr  output  16  registered LED pattern.
REQ-013 step  output  1  registered one-cycle pulse, high in the cycle after ledr changes due to a tick.
REQ-014 cur_mode  output  2  mode currently in effect.
REQ-015 running  output  1  high when state is RUN.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, APPLY; cmd_ready=1 in IDLE/RUN/PAUSE, 0 in APPLY (combinational from state).
REQ-017 Priority in any one cycle: command accept > stop > pause > start.
REQ-018 On accept: mode/period captured into holding regs; next state APPLY; no pattern step in the accept cycle.
REQ-019 APPLY (exactly 1 cycle): cur_mode<=held mode; period<=held period; count<=0; dir<=left; ledr<=seed (16'h0001 for modes 0-2, 16'hFFFF for mode 3); next state RUN.
REQ-020 IDLE: ledr and count held; start=1 -> RUN with count starting at its held value (0 after reset/stop).
REQ-021 RUN: if count>=period then count<=0 and pattern steps; else count<=count+1; first step occurs period+1 cycles after RUN entry with count=0.
REQ-022 period=0: pattern steps every RUN cycle; count stays 0; no wrap arithmetic beyond CNT_W (count never exceeds period).
REQ-023 Step rules: ROTL ledr<={ledr[14:0],ledr[15]}; ROTR ledr<={ledr[0],ledr[15:1]}; BLINK ledr<=~ledr.
REQ-024 BOUNCE: dir left: ledr[15]=1 -> dir<=right, ledr<=ledr>>1, else ledr<=ledr<<1; dir right: ledr[0]=1 -> dir<=left, ledr<=ledr<<1, else ledr<=ledr>>1.
REQ-025 RUN with pause=1 -> PAUSE; PAUSE: count, ledr, dir frozen; pause=0 -> RUN, counting resumes from the frozen count.
REQ-026 stop=1 in RUN/PAUSE -> IDLE; count<=0; ledr, cur_mode, period retained.
REQ-027 step=1 for exactly one cycle per pattern change caused by a tick; 0 in APPLY, IDLE and PAUSE.
REQ-028 Commands accepted in IDLE and PAUSE also pass through APPLY and end in RUN.

Reset
REQ-029 With rst=0 at a rising edge: state<=IDLE, ledr<=16'h0001, cur_mode<=0, period<=DEF_PERIOD, count<=0, dir<=left, step<=0; cmd_ready=1 after reset.
REQ-030 Reset mid-operation (any state, including APPLY) overrides all inputs that cycle; any pending command is discarded.

Verification
REQ-031 Reset, cmd mode=0 period=3 accepted -> APPLY then RUN; ledr 0001->0002->0004 with 4 cycles between changes, step pulsing each change.
REQ-032 mode=2 period=0 -> ledr 0001,0002,...,8000,4000,...,0001,0002 on consecutive cycles; no repeated 8000 or 0001.
REQ-033 mode=3 period=1 -> ledr FFFF,0000,FFFF alternating every 2 cycles; pause held 5 cycles mid-period -> no change, resumes with the remaining count.
REQ-034 In RUN, cmd_valid and stop high in the same cycle as count==period -> command wins, no step that cycle, cmd_ready=0 next cycle, ledr=seed after APPLY.
REQ-035 stop in RUN -> IDLE, ledr held, running=0; start -> first step after period+1 cycles; rst=0 during PAUSE -> ledr=0001, period=5000000, cur_mode=0.
